dmem_port_arbiter: RTL and testbench

//  Sequences and shares the read/write port (a/d/we/spo) of the 64x32 dual-port

---
 rtl/dmem_port_arbiter_if.sv | 48 ++++
 rtl/dmem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_port_arbiter_if.sv
// Bundles the two requester channels and the RAM read/write port of the
// data-memory arbiter.
//   m0_*/m1_* : req/we/addr/wdata toward the arbiter; gnt/rvalid/rdata back.
//   mem_*     : a/d/we toward the RAM; spo (asynchronous read data) back.
// Modports: master = requesters + RAM side, slave = arbiter side.
interface dmem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 6,
   parameter int unsigned DATA_W = 32
);
   logic              m0_req;
   logic              m0_we;
   logic [ADDR_W-1:0] m0_addr;
   logic [DATA_W-1:0] m0_wdata;
   logic              m0_gnt;
   logic              m0_rvalid;
   logic [DATA_W-1:0] m0_rdata;

   logic              m1_req;
   logic              m1_we;
   logic [ADDR_W-1:0] m1_addr;
   logic [DATA_W-1:0] m1_wdata;
   logic              m1_gnt;
   logic              m1_rvalid;
   logic [DATA_W-1:0] m1_rdata;

   logic [ADDR_W-1:0] mem_a;
   logic [DATA_W-1:0] mem_d;
   logic              mem_we;
   logic [DATA_W-1:0] mem_spo;

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata,
      input  m0_gnt, m0_rvalid, m0_rdata,
      output m1_req, m1_we, m1_addr, m1_wdata,
      input  m1_gnt, m1_rvalid, m1_rdata,
      input  mem_a, mem_d, mem_we,
      output mem_spo
   );

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      output m0_gnt, m0_rvalid, m0_rdata,
      input  m1_req, m1_we, m1_addr, m1_wdata,
      output m1_gnt, m1_rvalid, m1_rdata,
      output mem_a, mem_d, mem_we,
      input  mem_spo
   );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares the a/d/we/spo port of the distributed data RAM between the CPU
// datapath (m0) and the debug/IO unit (m1) with round-robin arbitration,
// one transaction per cycle and a registered read response. A clear engine
// sweeps CLR_VAL into every word after reset (optional) or on a clr pulse.
//   clk, rstn : clock, asynchronous active-low reset
//   clr       : one-cycle pulse starting a clear sweep (ignored while clearing)
//   busy      : high while the clear sweep runs
//   bus       : requester channels and RAM port (slave modport)
module dmem_port_arbiter #(
   parameter int unsigned     ADDR_W         = 6,
   parameter int unsigned     DATA_W         = 32,
   parameter logic [DATA_W-1:0] CLR_VAL      = '0,
   parameter bit              CLEAR_ON_RESET = 1'b1
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 clr,
   output logic                 busy,
   dmem_port_arbiter_if.slave   bus
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic {ST_CLEAR, ST_RUN} state_t;

   localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
   logic              rr_q, rr_d;

   logic              gnt0_c, gnt1_c;
   logic [ADDR_W-1:0] mem_a_c;
   logic [DATA_W-1:0] mem_d_c;
   logic              mem_we_c;

   logic              rvalid0_q, rvalid1_q;
   logic [DATA_W-1:0] rdata0_q, rdata1_q;

   // Next state, grant selection and RAM port mux
   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      rr_d      = rr_q;
      gnt0_c    = 1'b0;
      gnt1_c    = 1'b0;
      mem_a_c   = '0;
      mem_d_c   = '0;
      mem_we_c  = 1'b0;

      case (state_q)
         ST_CLEAR: begin
            mem_we_c  = 1'b1;
            mem_a_c   = clr_ptr_q;
            mem_d_c   = CLR_VAL;
            clr_ptr_d = clr_ptr_q + ADDR_W'(1);
            if (clr_ptr_q == LAST_ADDR) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // rr only matters on contention; a lone requester always wins
            if (bus.m0_req && (!bus.m1_req || !rr_q)) begin
               gnt0_c = 1'b1;
            end else if (bus.m1_req) begin
               gnt1_c = 1'b1;
            end

            if (gnt0_c) begin
               mem_a_c  = bus.m0_addr;
               mem_d_c  = bus.m0_wdata;
               mem_we_c = bus.m0_we;
               rr_d     = 1'b1;
            end else if (gnt1_c) begin
               mem_a_c  = bus.m1_addr;
               mem_d_c  = bus.m1_wdata;
               mem_we_c = bus.m1_we;
               rr_d     = 1'b0;
            end

            // A grant in the same cycle still completes; the sweep starts next
            if (clr) begin
               state_d   = ST_CLEAR;
               clr_ptr_d = '0;
            end
         end
         default: begin
            state_d   = RESET_STATE;
            clr_ptr_d = '0;
         end
      endcase

      // Keep the RAM and requesters quiet while reset is asserted
      if (!rstn) begin
         gnt0_c   = 1'b0;
         gnt1_c   = 1'b0;
         mem_a_c  = '0;
         mem_d_c  = '0;
         mem_we_c = 1'b0;
      end
   end

   // State, pointers and read response registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= RESET_STATE;
         clr_ptr_q <= '0;
         rr_q      <= 1'b0;
         busy      <= CLEAR_ON_RESET;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
         rr_q      <= rr_d;
         busy      <= (state_d == ST_CLEAR);
         rvalid0_q <= gnt0_c && !bus.m0_we;
         rvalid1_q <= gnt1_c && !bus.m1_we;
         if (gnt0_c && !bus.m0_we) begin
            rdata0_q <= bus.mem_spo;
         end
         if (gnt1_c && !bus.m1_we) begin
            rdata1_q <= bus.mem_spo;
         end
      end
   end

   assign bus.m0_gnt    = gnt0_c;
   assign bus.m1_gnt    = gnt1_c;
   assign bus.m0_rvalid = rvalid0_q;
   assign bus.m1_rvalid = rvalid1_q;
   assign bus.m0_rdata  = rdata0_q;
   assign bus.m1_rdata  = rdata1_q;
   assign bus.mem_a     = mem_a_c;
   assign bus.mem_d     = mem_d_c;
   assign bus.mem_we    = mem_we_c;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with an attached 64x32 RAM model.
// Expected read data is queued per requester when a read is driven and
// popped when that requester's rvalid is checked.
module tb_dmem_port_arbiter;

   logic clk = 1'b0;
   logic rstn;
   logic clr;
   logic busy;

   dmem_port_arbiter_if #(.ADDR_W(6), .DATA_W(32)) bus ();

   dmem_port_arbiter #(
      .ADDR_W(6), .DATA_W(32), .CLR_VAL(32'h0), .CLEAR_ON_RESET(1'b1)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .clr  (clr),
      .busy (busy),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // RAM model: synchronous write, asynchronous read
   logic [31:0] ram [64];
   always @(posedge clk) begin
      if (bus.mem_we) ram[bus.mem_a] <= bus.mem_d;
   end
   assign bus.mem_spo = ram[bus.mem_a];

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] q0[$];
   logic [31:0] q1[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Check rvalid of requester m and compare rdata with the queued expectation
   task automatic rv_chk(input int m, input string tag);
      logic [31:0] exp;
      chk({tag, "_rvalid"}, 32'(m == 0 ? bus.m0_rvalid : bus.m1_rvalid), 32'd1);
      if ((m == 0 ? q0.size() : q1.size()) == 0) begin
         n_tests++;
         n_fail++;
         $error("FAIL %s_queue observed=empty expected=entry", tag);
      end else begin
         exp = (m == 0) ? q0.pop_front() : q1.pop_front();
         chk({tag, "_rdata"}, (m == 0) ? bus.m0_rdata : bus.m1_rdata, exp);
      end
   endtask

   task automatic drv0(input logic req, input logic we, input logic [5:0] a, input logic [31:0] d);
      bus.m0_req = req; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d;
   endtask

   task automatic drv1(input logic req, input logic we, input logic [5:0] a, input logic [31:0] d);
      bus.m1_req = req; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expect a full 64-cycle sweep starting in the current cycle
   task automatic sweep_chk(input string tag);
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         chk({tag, "_busy"}, 32'(busy), 32'd1);
         chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'd1);
         chk({tag, "_mem_a"}, 32'(bus.mem_a), 32'(i));
         chk({tag, "_mem_d"}, bus.mem_d, 32'h0);
         chk({tag, "_gnt"}, 32'({bus.m0_gnt, bus.m1_gnt}), 32'd0);
      end
      @(negedge clk);
      chk({tag, "_busy_end"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int found;
      rstn = 1'b0;
      clr  = 1'b0;
      drv0(1'b0, 1'b0, 6'd0, 32'h0);
      drv1(1'b0, 1'b0, 6'd0, 32'h0);

      // Reset state
      #12;
      chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
      chk("rst_m0_gnt", 32'(bus.m0_gnt), 32'd0);
      chk("rst_m0_rvalid", 32'(bus.m0_rvalid), 32'd0);
      chk("rst_m1_rdata", bus.m1_rdata, 32'h0);

      // 1: clear sweep after reset
      step();
      rstn = 1'b1;
      sweep_chk("init_clr");

      // 2: m0 write then read of addr 1
      step();
      drv0(1'b1, 1'b1, 6'd1, 32'h1111);
      @(negedge clk);
      chk("t2_wr_gnt", 32'(bus.m0_gnt), 32'd1);
      step();
      drv0(1'b1, 1'b0, 6'd1, 32'h0);
      q0.push_back(32'h1111);
      @(negedge clk);
      chk("t2_rd_gnt", 32'(bus.m0_gnt), 32'd1);
      chk("t2_rvalid_early", 32'(bus.m0_rvalid), 32'd0);
      step();
      drv0(1'b0, 1'b0, 6'd0, 32'h0);
      drv1(1'b1, 1'b1, 6'd2, 32'h3333);
      @(negedge clk);
      rv_chk(0, "t2_rd");
      chk("t2_m1_wr_gnt", 32'(bus.m1_gnt), 32'd1);

      // 3: both requesting continuously -> strict alternation from m0
      step();
      drv0(1'b1, 1'b0, 6'd1, 32'h0);
      drv1(1'b1, 1'b0, 6'd2, 32'h0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("t3_m0_gnt%0d", k), 32'(bus.m0_gnt), 32'((k % 2) == 0));
         chk($sformatf("t3_m1_gnt%0d", k), 32'(bus.m1_gnt), 32'((k % 2) == 1));
         if ((k % 2) == 0) q0.push_back(32'h1111);
         else              q1.push_back(32'h3333);
         if (k > 0) begin
            if (((k - 1) % 2) == 0) begin
               rv_chk(0, $sformatf("t3_m0_%0d", k));
               chk($sformatf("t3_m1_idle%0d", k), 32'(bus.m1_rvalid), 32'd0);
            end else begin
               rv_chk(1, $sformatf("t3_m1_%0d", k));
               chk($sformatf("t3_m0_idle%0d", k), 32'(bus.m0_rvalid), 32'd0);
            end
         end
      end
      step();
      drv0(1'b0, 1'b0, 6'd0, 32'h0);
      drv1(1'b0, 1'b0, 6'd0, 32'h0);
      @(negedge clk);
      rv_chk(1, "t3_m1_last");

      // 4: contention on addr 5, write from m0 wins, m1 reads new data
      step();
      drv0(1'b1, 1'b1, 6'd5, 32'h2222);
      drv1(1'b1, 1'b0, 6'd5, 32'h0);
      @(negedge clk);
      chk("t4_m0_gnt", 32'(bus.m0_gnt), 32'd1);
      chk("t4_m1_wait", 32'(bus.m1_gnt), 32'd0);
      step();
      drv0(1'b0, 1'b0, 6'd0, 32'h0);
      q1.push_back(32'h2222);
      @(negedge clk);
      chk("t4_m1_gnt", 32'(bus.m1_gnt), 32'd1);
      chk("t4_wr_no_rvalid", 32'(bus.m0_rvalid), 32'd0);
      step();
      drv1(1'b0, 1'b0, 6'd0, 32'h0);
      @(negedge clk);
      rv_chk(1, "t4_rd");

      // 5: clr pulse, m1 read of addr 5 waits out the sweep
      step();
      clr = 1'b1;
      step();
      clr = 1'b0;
      drv1(1'b1, 1'b0, 6'd5, 32'h0);
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         chk($sformatf("t5_busy%0d", i), 32'(busy), 32'd1);
         chk($sformatf("t5_nogrant%0d", i), 32'(bus.m1_gnt), 32'd0);
      end
      @(negedge clk);
      chk("t5_busy_end", 32'(busy), 32'd0);
      chk("t5_m1_gnt", 32'(bus.m1_gnt), 32'd1);
      q1.push_back(32'h0);
      step();
      drv1(1'b0, 1'b0, 6'd0, 32'h0);
      @(negedge clk);
      rv_chk(1, "t5_rd");

      // clr in the same cycle as a read grant: grant and rvalid complete
      step();
      clr = 1'b1;
      drv0(1'b1, 1'b0, 6'd1, 32'h0);
      @(negedge clk);
      chk("t5b_m0_gnt", 32'(bus.m0_gnt), 32'd1);
      q0.push_back(32'h0);
      step();
      clr = 1'b0;
      drv0(1'b0, 1'b0, 6'd0, 32'h0);
      @(negedge clk);
      chk("t5b_busy", 32'(busy), 32'd1);
      rv_chk(0, "t5b_rd");
      chk("t5b_sweep_start", 32'(bus.mem_a), 32'd0);

      // 6: reset in the middle of the sweep
      found = 0;
      for (int i = 0; i < 100; i++) begin
         if (bus.mem_a == 6'd20) begin
            found = 1;
            break;
         end
         @(negedge clk);
      end
      chk("t6_reach_ptr20", 32'(found), 32'd1);
      #1;
      rstn = 1'b0;
      drv0(1'b1, 1'b0, 6'd1, 32'h0);
      #1;
      chk("t6_rst_mem_we", 32'(bus.mem_we), 32'd0);
      chk("t6_rst_m0_gnt", 32'(bus.m0_gnt), 32'd0);
      chk("t6_rst_mem_a", 32'(bus.mem_a), 32'd0);
      drv0(1'b0, 1'b0, 6'd0, 32'h0);
      step();
      rstn = 1'b1;
      sweep_chk("t6_reclr");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
